mem_arbiter: RTL and testbench

//  Sequences the single byte-wide RAM port between instruction fetch (IF) and the MEM stage (load/store driven

---
 rtl/mem_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide, 1-cycle-latency RAM port between IF fetches and MEM loads/stores.
// Define MEM_ARB_FAIR_EN for round-robin IF/MEM grants; otherwise MEM always wins over IF.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_inst,
  input  logic              mem_load,
  input  logic              mem_save,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [2:0]        mem_len,
  input  logic              mem_signed,
  output logic              mem_ready,
  output logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic              stall_req_if,
  output logic              stall_req_mem
);
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;
  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d, len_q, len_d, nxt_cnt, mem_beats;
  logic [1:0]        lane;
  logic              owner_q, owner_d, sgn_q, sgn_d;
  logic [ADDR_W-1:0] base_q, base_d, ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, buf_q, buf_d;
  logic [DATA_W-1:0] if_inst_q, if_inst_d, mem_rdata_q, mem_rdata_d;
  logic              ram_wr_q, ram_wr_d, if_ready_q, if_ready_d, mem_ready_q, mem_ready_d;
  logic [7:0]        ram_wdata_q, ram_wdata_d;
  logic              mem_pend, pick_mem;
`ifdef MEM_ARB_FAIR_EN
  logic              last_owner_q, last_owner_d;
`endif

  always_comb begin
    mem_pend = mem_load | mem_save;
`ifdef MEM_ARB_FAIR_EN
    // With both pending, the requester that was not served last wins.
    pick_mem = mem_pend & (~if_req | (last_owner_q == OWN_IF));
    last_owner_d = last_owner_q;
`else
    pick_mem = mem_pend;
`endif
    case (mem_len)
      3'd1:    mem_beats = 3'd1;
      3'd2:    mem_beats = 3'd2;
      default: mem_beats = 3'd4;
    endcase
    nxt_cnt     = cnt_q + 3'd1;
    lane        = cnt_q[1:0] - 2'd1;
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    owner_d     = owner_q;
    sgn_d       = sgn_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_wr_d    = 1'b0;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (mem_pend || if_req) begin
          cnt_d = 3'd0;
          buf_d = '0;
          if (pick_mem) begin
            owner_d    = OWN_MEM;
            base_d     = mem_addr;
            wdata_d    = mem_wdata;
            len_d      = mem_beats;
            sgn_d      = mem_signed;
            ram_addr_d = mem_addr;
            if (mem_save) begin
              state_d     = S_WR;
              ram_wr_d    = 1'b1;
              ram_wdata_d = mem_wdata[7:0];
            end else begin
              state_d = S_RD;
            end
          end else begin
            owner_d    = OWN_IF;
            base_d     = if_addr;
            len_d      = 3'd4;
            sgn_d      = 1'b0;
            ram_addr_d = if_addr;
            state_d    = S_RD;
          end
`ifdef MEM_ARB_FAIR_EN
          last_owner_d = owner_d;
`endif
        end
      end
      S_RD: begin
        // Read data trails the address by one cycle, so lane cnt-1 lands while cnt is issued.
        if (cnt_q != 3'd0) buf_d[{lane, 3'b000} +: 8] = ram_rdata;
        if (cnt_q == len_q) begin
          state_d = S_DONE;
          if (owner_q == OWN_IF) begin
            if_ready_d = 1'b1;
            if_inst_d  = buf_d;
          end else begin
            mem_ready_d = 1'b1;
            case (len_q)
              3'd1:    mem_rdata_d = {{24{sgn_q & buf_d[7]}}, buf_d[7:0]};
              3'd2:    mem_rdata_d = {{16{sgn_q & buf_d[15]}}, buf_d[15:0]};
              default: mem_rdata_d = buf_d;
            endcase
          end
        end else begin
          cnt_d = nxt_cnt;
          if (nxt_cnt < len_q) ram_addr_d = base_q + ADDR_W'(nxt_cnt);
        end
      end
      S_WR: begin
        cnt_d = nxt_cnt;
        if (nxt_cnt < len_q) begin
          ram_wr_d    = 1'b1;
          ram_addr_d  = base_q + ADDR_W'(nxt_cnt);
          ram_wdata_d = wdata_q[{nxt_cnt[1:0], 3'b000} +: 8];
        end else begin
          state_d     = S_DONE;
          mem_ready_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      owner_q     <= OWN_IF;
      sgn_q       <= 1'b0;
      base_q      <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_wr_q    <= 1'b0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if_inst_q   <= '0;
      mem_rdata_q <= '0;
`ifdef MEM_ARB_FAIR_EN
      last_owner_q <= OWN_MEM;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      owner_q     <= owner_d;
      sgn_q       <= sgn_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_wr_q    <= ram_wr_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
`ifdef MEM_ARB_FAIR_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  assign ram_addr      = ram_addr_q;
  assign ram_wr        = ram_wr_q;
  assign ram_wdata     = ram_wdata_q;
  assign if_ready      = if_ready_q;
  assign if_inst       = if_inst_q;
  assign mem_ready     = mem_ready_q;
  assign mem_rdata     = mem_rdata_q;
  // Requests stall until the cycle their own ready pulse is out; held at 0 during reset.
  assign stall_req_mem = rst_n & mem_pend & ~((state_q == S_DONE) && (owner_q == OWN_MEM));
  assign stall_req_if  = rst_n & if_req & ~((state_q == S_DONE) && (owner_q == OWN_IF));
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random fetch/load/store traffic against a byte-array model.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ready;
  logic [31:0] if_inst;
  logic        mem_load = 1'b0;
  logic        mem_save = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [2:0]  mem_len = 3'd4;
  logic        mem_signed = 1'b0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = '0;
  logic        stall_req_if;
  logic        stall_req_mem;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_inst(if_inst),
    .mem_load(mem_load), .mem_save(mem_save), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_len(mem_len), .mem_signed(mem_signed), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .stall_req_if(stall_req_if), .stall_req_mem(stall_req_mem)
  );

  always #5 clk = ~clk;

  logic [7:0]  ram_mem [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  logic [31:0] wr_a_q[$];
  logic [7:0]  wr_d_q[$];
  logic [31:0] a_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  bit          last_was_mem = 1'b1;

  function automatic logic [7:0] rd_ram(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] rd_ref(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  // Synchronous RAM: read-before-write, data one cycle after the address.
  always @(posedge clk) begin
    ram_rdata <= rd_ram(ram_addr);
    if (ram_wr) begin
      wr_a_q.push_back(ram_addr);
      wr_d_q.push_back(ram_wdata);
      ram_mem[ram_addr] = ram_wdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    ram_mem[a] = b;
    ref_mem[a] = b;
  endtask

  // Little-endian read of nb bytes, extended to 32 bits by value range.
  function automatic logic [31:0] model_read(input logic [31:0] a, input int nb, input bit sgn);
    longint v;
    v = 0;
    for (int i = 0; i < nb; i++) v += longint'(rd_ref(a + 32'(i))) << (8 * i);
    if (sgn && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v -= longint'(1) << (8 * nb);
    return 32'(v);
  endfunction

  // kind: 0 fetch, 1 load, 2 save, 3 load+save together (acts as save)
  task automatic run_txn(input int kind, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [2:0] len, input bit sgn, output logic [31:0] data);
    int nb, cyc;
    bit seen, is_wr, is_if;
    logic [31:0] exp_data;
    is_if = (kind == 0);
    is_wr = (kind >= 2);
    nb = is_if ? 4 : (len == 3'd1) ? 1 : (len == 3'd2) ? 2 : 4;
    exp_data = is_if ? model_read(addr, 4, 1'b0) : model_read(addr, nb, sgn);
    @(negedge clk);
    if_req = is_if;
    if_addr = addr;
    mem_load = (kind == 1) || (kind == 3);
    mem_save = is_wr;
    mem_addr = addr;
    mem_wdata = wd;
    mem_len = len;
    mem_signed = sgn;
    wr_a_q.delete();
    wr_d_q.delete();
    a_q.delete();
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 30) begin
      @(negedge clk);
      cyc++;
      a_q.push_back(ram_addr);
      seen = is_if ? if_ready : mem_ready;
      if (!seen && cyc == 1) check("stall_wait", 32'(is_if ? stall_req_if : stall_req_mem), 32'd1);
    end
    check("ready_seen", 32'(seen), 32'd1);
    check("latency", 32'(cyc), is_wr ? 32'(nb + 1) : 32'(nb + 2));
    check("stall_at_ready", 32'(is_if ? stall_req_if : stall_req_mem), 32'd0);
    check("other_ready", 32'(is_if ? mem_ready : if_ready), 32'd0);
    data = is_if ? if_inst : mem_rdata;
    if (is_wr) begin
      check("wr_beats", 32'(wr_a_q.size()), 32'(nb));
      for (int i = 0; i < nb; i++) begin
        if (i < wr_a_q.size()) begin
          check("wr_addr", wr_a_q[i], addr + 32'(i));
          check("wr_data", 32'(wr_d_q[i]), 32'(wd[8 * i +: 8]));
        end
        ref_mem[addr + 32'(i)] = wd[8 * i +: 8];
      end
    end else begin
      check(is_if ? "if_inst" : "mem_rdata", data, exp_data);
      for (int i = 0; i < nb; i++)
        if (i < a_q.size()) check("rd_addr", a_q[i], addr + 32'(i));
      check("no_write", 32'(wr_a_q.size()), 32'd0);
    end
    last_was_mem = !is_if;
    if_req = 1'b0;
    mem_load = 1'b0;
    mem_save = 1'b0;
    @(negedge clk);
    check("ready_pulse", 32'(if_ready | mem_ready), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic [2:0]  len_tab[7];
    bit          exp_order[$];
    bit          got_order[$];
    bit          prev_mem, cur_mem;
    int          kind;
    logic [31:0] addr;
    len_tab = '{3'd1, 3'd2, 3'd4, 3'd4, 3'd0, 3'd3, 3'd7};

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_if_ready", 32'(if_ready), 32'd0);
    check("rst_mem_ready", 32'(mem_ready), 32'd0);
    check("rst_ram_wr", 32'(ram_wr), 32'd0);
    check("rst_ram_addr", ram_addr, 32'd0);
    check("rst_if_inst", if_inst, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    rst_n = 1'b1;

    // Fetch from 0x100
    poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33); poke(32'h103, 8'h44);
    run_txn(0, 32'h100, 32'h0, 3'd4, 1'b0, d);
    check("fetch_word", d, 32'h4433_2211);

    // Byte and half loads with sign/zero extension
    poke(32'h8, 8'h80); poke(32'h9, 8'hFF);
    run_txn(1, 32'h8, 32'h0, 3'd1, 1'b1, d);
    check("lb_signed", d, 32'hFFFF_FF80);
    run_txn(1, 32'h8, 32'h0, 3'd1, 1'b0, d);
    check("lb_unsigned", d, 32'h0000_0080);
    run_txn(1, 32'h8, 32'h0, 3'd2, 1'b1, d);
    check("lh_signed", d, 32'hFFFF_FF80);

    // Half store, neighbour byte left alone
    poke(32'h22, 8'h5A);
    run_txn(2, 32'h20, 32'hAABB_CCDD, 3'd2, 1'b0, d);
    check("sh_byte0", 32'(rd_ram(32'h20)), 32'h0000_00DD);
    check("sh_byte1", 32'(rd_ram(32'h21)), 32'h0000_00CC);
    check("sh_untouched", 32'(rd_ram(32'h22)), 32'h0000_005A);

    // Fetch across the top of the address space
    poke(32'hFFFF_FFFE, 8'hA1); poke(32'hFFFF_FFFF, 8'hB2); poke(32'h0, 8'hC3); poke(32'h1, 8'hD4);
    run_txn(0, 32'hFFFF_FFFE, 32'h0, 3'd4, 1'b0, d);
    check("wrap_word", d, 32'hD4C3_B2A1);

    // Reset in the middle of a word store, after one byte has landed
    for (int i = 0; i < 4; i++) poke(32'h40 + 32'(i), 8'h77);
    @(negedge clk);
    mem_save = 1'b1; mem_load = 1'b0; mem_addr = 32'h40; mem_wdata = 32'h1122_3344; mem_len = 3'd4;
    repeat (2) @(negedge clk);
    check("mid_wr_active", 32'(ram_wr), 32'd1);
    check("mid_wr_addr", ram_addr, 32'h41);
    rst_n = 1'b0;
    mem_save = 1'b0;
    #1;
    check("rst_async_wr", 32'(ram_wr), 32'd0);
    check("rst_async_addr", ram_addr, 32'd0);
    check("rst_async_wdata", 32'(ram_wdata), 32'd0);
    check("rst_async_ready", 32'(mem_ready), 32'd0);
    check("rst_async_stall", 32'(stall_req_mem), 32'd0);
    ref_mem[32'h40] = 8'h44;
    last_was_mem = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_ready", 32'(mem_ready | if_ready), 32'd0);
      check("post_rst_wr", 32'(ram_wr), 32'd0);
    end

    // Contention: an IF fetch first, then both request together and stay high
    run_txn(0, 32'h100, 32'h0, 3'd4, 1'b0, d);
    prev_mem = last_was_mem;
    for (int g = 0; g < 3; g++) begin
`ifdef MEM_ARB_FAIR_EN
      cur_mem = !prev_mem;
`else
      cur_mem = 1'b1;
`endif
      exp_order.push_back(cur_mem);
      prev_mem = cur_mem;
    end
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    mem_load = 1'b1; mem_save = 1'b0; mem_addr = 32'h8; mem_len = 3'd4; mem_signed = 1'b0;
    for (int c = 0; c < 60 && got_order.size() < 3; c++) begin
      @(negedge clk);
      if (mem_ready) begin
        got_order.push_back(1'b1);
        check("contend_if_stalled", 32'(stall_req_if), 32'd1);
      end
      if (if_ready) got_order.push_back(1'b0);
    end
    check("contend_grants", 32'(got_order.size()), 32'd3);
    for (int g = 0; g < 3; g++)
      if (g < got_order.size()) check("contend_order", 32'(got_order[g]), 32'(exp_order[g]));
    if_req = 1'b0; mem_load = 1'b0;
    if (got_order.size() > 0) last_was_mem = got_order[got_order.size() - 1];
    repeat (2) @(negedge clk);

    // Random traffic in a small window plus the wrap region
    for (int i = 0; i < 64; i++) poke(32'h1000 + 32'(i), 8'($urandom));
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else addr = 32'h1000 + 32'($urandom_range(0, 60));
      run_txn(kind, addr, $urandom, len_tab[$urandom_range(0, 6)], 1'($urandom_range(0, 1)), d);
    end

    foreach (ref_mem[k]) check("ram_byte", 32'(rd_ram(k)), 32'(ref_mem[k]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
